alu_mux_arbiter: RTL and testbench

//  Shares one ALU (operand pair plus 3-bit op select into the 8:1 result mux) among N_REQ requesters.

---
 rtl/alu_mux_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_mux_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mux_arbiter.sv
// alu_mux_arbiter: shares one combinational ALU among N_REQ requesters.
// A winner is chosen when the arbiter is idle, and its op/operands are latched onto the ALU inputs.
// The ALU inputs are then held for SETTLE_CYCLES so the ALU output can settle.
// The ALU result is then captured and returned with a one-cycle done pulse.
// Optional macro ALU_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of the default round-robin.
module alu_mux_arbiter #(
  parameter int N_REQ         = 4,
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [3*N_REQ-1:0]     op_flat,
  input  logic [WIDTH*N_REQ-1:0] a_flat,
  input  logic [WIDTH*N_REQ-1:0] b_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic [2:0]             alu_sel,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [WIDTH-1:0]       alu_result
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [2:0]        sel_q, sel_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     rr_q, rr_d;
`endif

  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic [2:0]        win_op;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;

  // Winner search: round-robin is done as two passes over fixed indices
  // (indices >= rr_ptr first, then from 0) so every index is a constant.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[i] && (IW'(i) >= rr_q)) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
`endif
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end

  // Select the winner's op and operands from the flattened request buses.
  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_op = op_flat[3*i +: 3];
        win_a  = a_flat[WIDTH*i +: WIDTH];
        win_b  = b_flat[WIDTH*i +: WIDTH];
      end
    end
  end

  // FSM next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    result_d = result_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    win_d    = win_q;
    rr_d     = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          sel_d          = win_op;
          a_d            = win_a;
          b_d            = win_b;
          cnt_d          = CW'(SETTLE_CYCLES - 1);
          state_d        = SETTLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
          win_d          = win_idx;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          result_d = alu_result;
          done_d   = gnt_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_d  = '0;
        gnt_d   = '0;
        state_d = IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_d    = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      win_q    <= '0;
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      win_q    <= win_d;
      rr_q     <= rr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign result  = result_q;
  assign alu_sel = sel_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// Directed testbench for alu_mux_arbiter with a small combinational ALU stub.
// Expected grant orders follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_mux_arbiter;

  localparam int N_REQ  = 4;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     op_flat;
  logic [WIDTH*N_REQ-1:0] a_flat;
  logic [WIDTH*N_REQ-1:0] b_flat;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       result;
  logic [2:0]             alu_sel;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [WIDTH-1:0]       alu_result;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Per-requester op/operands and hand-computed stub results.
  logic [2:0]  op_t  [N_REQ] = '{3'd0, 3'd1, 3'd3, 3'd4};
  logic [31:0] a_t   [N_REQ] = '{32'd12, 32'd12, 32'd20, 32'd6};
  logic [31:0] b_t   [N_REQ] = '{32'd10, 32'd3, 32'd7, 32'd3};
  logic [31:0] res_t [N_REQ] = '{32'd8, 32'd15, 32'd13, 32'd5};

`ifdef ALU_ARB_FIXED_PRIO_EN
  int cont_ord [5] = '{0, 0, 0, 0, 0};
  int wrap_ord [2] = '{0, 0};
  int pair_ord [4] = '{1, 1, 1, 1};
`else
  int cont_ord [5] = '{0, 1, 2, 3, 0};
  int wrap_ord [2] = '{3, 0};
  int pair_ord [4] = '{1, 2, 1, 2};
`endif

  always #5 clk = ~clk;

  alu_mux_arbiter #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .op_flat(op_flat),
    .a_flat(a_flat),
    .b_flat(b_flat),
    .gnt(gnt),
    .done(done),
    .result(result),
    .alu_sel(alu_sel),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_result(alu_result)
  );

  // ALU stub standing in for the 8:1 result mux.
  always_comb begin
    case (alu_sel)
      3'd0:    alu_result = alu_a & alu_b;
      3'd1:    alu_result = alu_a | alu_b;
      3'd2:    alu_result = alu_a + alu_b;
      3'd3:    alu_result = alu_a - alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = alu_a << alu_b[4:0];
      3'd6:    alu_result = alu_a;
      default: alu_result = alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_flat[3*i +: 3]        = op;
    a_flat[WIDTH*i +: WIDTH] = a;
    b_flat[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic load_table();
    for (int i = 0; i < N_REQ; i++) load(i, op_t[i], a_t[i], b_t[i]);
  endtask

  // One full operation; the next rising edge must be the grant edge.
  task automatic run_op(input string tag, input int w);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    tick();
    check({tag, ".gnt"}, gnt, oh);
    check({tag, ".done0"}, done, '0);
    check({tag, ".sel"}, alu_sel, op_t[w]);
    check({tag, ".a"}, alu_a, a_t[w]);
    check({tag, ".b"}, alu_b, b_t[w]);
    tick();
    check({tag, ".gnt_hold"}, gnt, oh);
    check({tag, ".done1"}, done, '0);
    tick();
    check({tag, ".done"}, done, oh);
    check({tag, ".res"}, result, res_t[w]);
    check({tag, ".gnt_done"}, gnt, oh);
    tick();
    check({tag, ".gnt_clr"}, gnt, '0);
    check({tag, ".done_clr"}, done, '0);
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    op_flat = '0;
    a_flat  = '0;
    b_flat  = '0;
    tick();
    tick();
    check("rst.gnt", gnt, '0);
    check("rst.done", done, '0);
    check("rst.result", result, '0);
    check("rst.sel", alu_sel, '0);
    check("rst.a", alu_a, '0);
    check("rst.b", alu_b, '0);

    // Single op on requester 0, operand changed and req dropped after grant.
    reset = 1'b0;
    load(0, 3'd2, 32'd5, 32'd3);
    req = 4'b0001;
    tick();
    check("single.gnt", gnt, 4'b0001);
    check("single.sel", alu_sel, 3'd2);
    check("single.a", alu_a, 32'd5);
    check("single.b", alu_b, 32'd3);
    check("single.done0", done, '0);
    load(0, 3'd2, 32'd9, 32'd3);
    req = '0;
    tick();
    check("single.gnt1", gnt, 4'b0001);
    check("single.done1", done, '0);
    check("opchg.a1", alu_a, 32'd5);
    check("single.sel1", alu_sel, 3'd2);
    tick();
    check("single.done", done, 4'b0001);
    check("single.res", result, 32'd8);
    check("opchg.a2", alu_a, 32'd5);
    check("single.sel2", alu_sel, 3'd2);
    tick();
    check("single.done_clr", done, '0);
    check("single.gnt_clr", gnt, '0);
    check("single.res_hold", result, 32'd8);
    check("single.sel_hold", alu_sel, 3'd2);
    tick();
    check("idle.gnt", gnt, '0);
    check("idle.res_hold", result, 32'd8);

    // Reset in the middle of SETTLE abandons the op.
    load_table();
    req = 4'b0010;
    tick();
    check("mid.gnt", gnt, 4'b0010);
    tick();
    reset = 1'b1;
    req   = '0;
    tick();
    check("mid.rst1.gnt", gnt, '0);
    check("mid.rst1.done", done, '0);
    tick();
    check("mid.rst2.gnt", gnt, '0);
    check("mid.rst2.done", done, '0);
    check("mid.rst2.result", result, '0);
    check("mid.rst2.sel", alu_sel, '0);
    check("mid.rst2.a", alu_a, '0);
    check("mid.rst2.b", alu_b, '0);
    reset = 1'b0;
    tick();
    check("mid.post1.done", done, '0);
    tick();
    check("mid.post2.done", done, '0);
    check("mid.post2.gnt", gnt, '0);
    // Pointer back at 0 after reset: requester 0 wins over 1.
    req = 4'b0011;
    run_op("mid.op0", 0);
    run_op("mid.op1", 1);
    req = '0;
    tick();

    // Contention: all four requesting from reset.
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    check("cont.rst.gnt", gnt, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) run_op($sformatf("cont%0d", i), cont_ord[i]);
    req = '0;
    tick();

    // Wrap: requester 2 finishes (pointer -> 3), then 0 and 3 contend.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 4'b0100;
    tick();
    check("wrap.g2", gnt, 4'b0100);
    req = 4'b1001;
    tick();
    check("wrap.ignore", gnt, 4'b0100);
    tick();
    check("wrap.d2", done, 4'b0100);
    check("wrap.r2", result, res_t[2]);
    tick();
    check("wrap.clr", gnt, '0);
    run_op("wrap.first", wrap_ord[0]);
    run_op("wrap.second", wrap_ord[1]);
    req = '0;
    tick();

    // Requesters 1 and 2 held.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 4'b0110;
    for (int i = 0; i < 4; i++) run_op($sformatf("pair%0d", i), pair_ord[i]);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
